// File: rtl/hazard_forward_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/forwarding controller:
// forwarding-mux encodings, controller state codes and the select priority helper.
package hazard_forward_ctrl_pkg;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  typedef enum logic [1:0] {
    ST_RUN        = 2'b00,
    ST_LOAD_STALL = 2'b01,
    ST_FLUSH      = 2'b10
  } state_t;

  // The youngest producer wins: an EX-stage result shadows an older MEM-stage one.
  function automatic logic [1:0] select_fwd(input logic ex_hit, input logic mem_hit);
    return ex_hit ? FWD_EXMEM : (mem_hit ? FWD_MEMWB : FWD_REG);
  endfunction

endpackage

// File: rtl/hazard_reg_match.sv
// Single source-vs-producer comparator; register 0 is hard-wired and never a dependency.
module hazard_reg_match #(
  parameter int REG_AW = 5
) (
  input  logic              valid,
  input  logic              reg_write,
  input  logic [REG_AW-1:0] src,
  input  logic [REG_AW-1:0] dest,
  output logic              hit
);

  assign hit = valid & reg_write & (dest == src) & (src != '0);

endmodule

// File: rtl/hazard_forward_ctrl.sv
// RAW hazard detection, operand forwarding selects and stall/flush sequencing for a 5-stage MIPS pipe.
// Define HAZARD_FORWARDING_EN for forwarding; otherwise every dependency on EX/MEM stalls.
module hazard_forward_ctrl
  import hazard_forward_ctrl_pkg::*;
#(
  parameter int REG_AW       = 5,
  parameter int CNT_W        = 16,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_stall,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [REG_AW-1:0] id_dest,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              ex_branch_taken,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic [CNT_W-1:0]  stall_count,
  output logic [1:0]        state
);

  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  state_t state_q, state_d;
  logic [FC_W-1:0] flush_left_q, flush_left_d;

  // The WB stage is not tracked: the register file is write-before-read, so it never matters.
  logic              ex_valid, ex_reg_write, ex_mem_read;
  logic [REG_AW-1:0] ex_dest;
  logic              mem_valid, mem_reg_write;
  logic [REG_AW-1:0] mem_dest;

  logic rs_ex_hit, rt_ex_hit, rs_mem_hit, rt_mem_hit;
  logic load_use, hazard, hazard_stall;

  hazard_reg_match #(.REG_AW(REG_AW)) u_rs_ex (
    .valid(ex_valid), .reg_write(ex_reg_write), .src(id_rs), .dest(ex_dest), .hit(rs_ex_hit)
  );
  hazard_reg_match #(.REG_AW(REG_AW)) u_rt_ex (
    .valid(ex_valid), .reg_write(ex_reg_write), .src(id_rt), .dest(ex_dest), .hit(rt_ex_hit)
  );
  hazard_reg_match #(.REG_AW(REG_AW)) u_rs_mem (
    .valid(mem_valid), .reg_write(mem_reg_write), .src(id_rs), .dest(mem_dest), .hit(rs_mem_hit)
  );
  hazard_reg_match #(.REG_AW(REG_AW)) u_rt_mem (
    .valid(mem_valid), .reg_write(mem_reg_write), .src(id_rt), .dest(mem_dest), .hit(rt_mem_hit)
  );

  assign load_use = id_valid & ex_mem_read &
                    ((id_uses_rs & rs_ex_hit) | (id_uses_rt & rt_ex_hit));

`ifdef HAZARD_FORWARDING_EN
  assign hazard = load_use;
`else
  // Without forwarding a consumer must wait until its producer has left MEM.
  assign hazard = load_use |
                  (id_valid & ((id_uses_rs & (rs_ex_hit | rs_mem_hit)) |
                               (id_uses_rt & (rt_ex_hit | rt_mem_hit))));
`endif

  // Priority: memory freeze, then taken branch, then pending flush cycles, then hazard stall.
  always_comb begin
    state_d      = state_q;
    flush_left_d = flush_left_q;
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    hazard_stall = 1'b0;
    if (mem_stall) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
    end else if (ex_branch_taken) begin
      ifid_flush   = 1'b1;
      idex_bubble  = 1'b1;
      state_d      = ST_FLUSH;
      flush_left_d = FC_W'(FLUSH_CYCLES - 1);
    end else if (state_q == ST_FLUSH && flush_left_q != '0) begin
      ifid_flush   = 1'b1;
      idex_bubble  = 1'b1;
      flush_left_d = flush_left_q - 1'b1;
      state_d      = (flush_left_q == FC_W'(1)) ? ST_RUN : ST_FLUSH;
    end else if (hazard) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idex_bubble  = 1'b1;
      hazard_stall = 1'b1;
      state_d      = ST_LOAD_STALL;
    end else begin
      state_d = ST_RUN;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_RUN;
      flush_left_q  <= '0;
      ex_valid      <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_dest       <= '0;
      mem_valid     <= 1'b0;
      mem_reg_write <= 1'b0;
      mem_dest      <= '0;
      stall_count   <= '0;
    end else if (!mem_stall) begin
      state_q       <= state_d;
      flush_left_q  <= flush_left_d;
      ex_valid      <= id_valid & ~idex_bubble;
      ex_reg_write  <= id_reg_write;
      ex_mem_read   <= id_mem_read;
      ex_dest       <= id_dest;
      mem_valid     <= ex_valid;
      mem_reg_write <= ex_reg_write;
      mem_dest      <= ex_dest;
      if (hazard_stall && stall_count != {CNT_W{1'b1}}) begin
        stall_count <= stall_count + 1'b1;
      end
    end
  end

`ifdef HAZARD_FORWARDING_EN
  // Selects travel with the instruction into EX; a bubble gets register-file operands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fwd_a_sel <= FWD_REG;
      fwd_b_sel <= FWD_REG;
    end else if (!mem_stall) begin
      if (id_valid && !idex_bubble) begin
        fwd_a_sel <= select_fwd(rs_ex_hit, rs_mem_hit);
        fwd_b_sel <= select_fwd(rt_ex_hit, rt_mem_hit);
      end else begin
        fwd_a_sel <= FWD_REG;
        fwd_b_sel <= FWD_REG;
      end
    end
  end
`else
  assign fwd_a_sel = FWD_REG;
  assign fwd_b_sel = FWD_REG;
`endif

  assign state = state_q;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Self-checking bench for hazard_forward_ctrl: directed pipeline scenarios plus random traffic,
// compared cycle by cycle against an instruction-level model of the in-flight producers.
module tb_hazard_forward_ctrl;
  import hazard_forward_ctrl_pkg::*;

  localparam int CNT_W        = 4;
  localparam int FLUSH_CYCLES = 1;
  localparam int CNT_MAX      = (1 << CNT_W) - 1;

  typedef struct packed {
    bit       v;
    bit [4:0] rs;
    bit [4:0] rt;
    bit       urs;
    bit       urt;
    bit [4:0] dest;
    bit       rw;
    bit       mr;
  } instr_t;

  typedef struct packed {
    bit       v;
    bit       rw;
    bit       mr;
    bit [4:0] dest;
  } entry_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             mem_stall;
  logic             id_valid;
  logic [4:0]       id_rs, id_rt, id_dest;
  logic             id_uses_rs, id_uses_rt, id_reg_write, id_mem_read;
  logic             ex_branch_taken;
  logic             pc_write, ifid_write, ifid_flush, idex_bubble;
  logic [1:0]       fwd_a_sel, fwd_b_sel;
  logic [CNT_W-1:0] stall_count;
  logic [1:0]       state;

  int compare_count = 0;
  int miscompares   = 0;

  // Instruction-level model: inflight[0] is the instruction now in EX, inflight[1] the one in MEM.
  entry_t     inflight[$];
  state_t     m_state;
  int         m_flush_left;
  int         m_count;
  logic [1:0] m_fwd_a, m_fwd_b;
  bit         exp_pc_write, exp_ifid_write, exp_ifid_flush, exp_idex_bubble, exp_stall;

  hazard_forward_ctrl #(.REG_AW(5), .CNT_W(CNT_W), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
    .clk(clk), .reset(reset), .mem_stall(mem_stall), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_dest(id_dest), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .ex_branch_taken(ex_branch_taken), .pc_write(pc_write), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .fwd_a_sel(fwd_a_sel),
    .fwd_b_sel(fwd_b_sel), .stall_count(stall_count), .state(state)
  );

  always #5 clk = ~clk;

  function automatic instr_t mk(bit v, bit [4:0] rs, bit [4:0] rt, bit urs, bit urt,
                                bit [4:0] dest, bit rw, bit mr);
    instr_t i;
    i.v = v; i.rs = rs; i.rt = rt; i.urs = urs; i.urt = urt;
    i.dest = dest; i.rw = rw; i.mr = mr;
    return i;
  endfunction

  function automatic bit hits(bit [4:0] src, entry_t e);
    return e.v && e.rw && (e.dest == src) && (src != 5'd0);
  endfunction

  task automatic applyStimulus(input instr_t ins, input bit br, input bit ms);
    id_valid        = ins.v;
    id_rs           = ins.rs;
    id_rt           = ins.rt;
    id_uses_rs      = ins.urs;
    id_uses_rt      = ins.urt;
    id_dest         = ins.dest;
    id_reg_write    = ins.rw;
    id_mem_read     = ins.mr;
    ex_branch_taken = br;
    mem_stall       = ms;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compare_count++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic resetModel();
    entry_t empty;
    empty = '0;
    inflight.delete();
    inflight.push_back(empty);
    inflight.push_back(empty);
    m_state      = ST_RUN;
    m_flush_left = 0;
    m_count      = 0;
    m_fwd_a      = FWD_REG;
    m_fwd_b      = FWD_REG;
  endtask

  // One clock: check outputs at the falling edge, then advance the model at the rising edge.
  task automatic runCycle();
    entry_t ex, mem, ne;
    bit use_a, use_b, load_dep, any_dep, stall_req, flushing;
    logic [1:0] nxt_a, nxt_b;
    @(negedge clk);
    ex       = inflight[0];
    mem      = inflight[1];
    use_a    = id_valid && id_uses_rs;
    use_b    = id_valid && id_uses_rt;
    load_dep = ex.mr && ((use_a && hits(id_rs, ex)) || (use_b && hits(id_rt, ex)));
    any_dep  = (use_a && (hits(id_rs, ex) || hits(id_rs, mem))) ||
               (use_b && (hits(id_rt, ex) || hits(id_rt, mem)));
`ifdef HAZARD_FORWARDING_EN
    stall_req = load_dep;
`else
    stall_req = load_dep || any_dep;
`endif
    flushing  = (m_state == ST_FLUSH) && (m_flush_left > 0);
    exp_stall = 1'b0;
    if (mem_stall) begin
      {exp_pc_write, exp_ifid_write, exp_ifid_flush, exp_idex_bubble} = 4'b0000;
    end else if (ex_branch_taken || flushing) begin
      {exp_pc_write, exp_ifid_write, exp_ifid_flush, exp_idex_bubble} = 4'b1111;
    end else if (stall_req) begin
      {exp_pc_write, exp_ifid_write, exp_ifid_flush, exp_idex_bubble} = 4'b0001;
      exp_stall = 1'b1;
    end else begin
      {exp_pc_write, exp_ifid_write, exp_ifid_flush, exp_idex_bubble} = 4'b1100;
    end
    checkOutput("pc_write",    pc_write,    exp_pc_write);
    checkOutput("ifid_write",  ifid_write,  exp_ifid_write);
    checkOutput("ifid_flush",  ifid_flush,  exp_ifid_flush);
    checkOutput("idex_bubble", idex_bubble, exp_idex_bubble);
    checkOutput("fwd_a_sel",   fwd_a_sel,   m_fwd_a);
    checkOutput("fwd_b_sel",   fwd_b_sel,   m_fwd_b);
    checkOutput("stall_count", stall_count, m_count);
    checkOutput("state",       state,       m_state);
    @(posedge clk);
    if (!mem_stall) begin
      nxt_a = FWD_REG;
      nxt_b = FWD_REG;
`ifdef HAZARD_FORWARDING_EN
      if (id_valid && !exp_idex_bubble) begin
        nxt_a = hits(id_rs, ex) ? FWD_EXMEM : (hits(id_rs, mem) ? FWD_MEMWB : FWD_REG);
        nxt_b = hits(id_rt, ex) ? FWD_EXMEM : (hits(id_rt, mem) ? FWD_MEMWB : FWD_REG);
      end
`endif
      m_fwd_a = nxt_a;
      m_fwd_b = nxt_b;
      if (ex_branch_taken) begin
        m_state      = ST_FLUSH;
        m_flush_left = FLUSH_CYCLES - 1;
      end else if (flushing) begin
        m_state      = (m_flush_left == 1) ? ST_RUN : ST_FLUSH;
        m_flush_left = m_flush_left - 1;
      end else begin
        m_state = exp_stall ? ST_LOAD_STALL : ST_RUN;
      end
      if (exp_stall && m_count < CNT_MAX) m_count++;
      ne.v    = id_valid && !exp_idex_bubble;
      ne.rw   = id_reg_write;
      ne.mr   = id_mem_read;
      ne.dest = id_dest;
      inflight.push_front(ne);
      void'(inflight.pop_back());
    end
    #1;
  endtask

  // Present an instruction in ID and hold it there while the pipeline refuses it.
  task automatic issueInstr(input instr_t ins);
    applyStimulus(ins, 1'b0, 1'b0);
    runCycle();
    for (int k = 0; k < 4 && !exp_pc_write; k++) runCycle();
  endtask

  instr_t nop;
  logic [CNT_W-1:0] base;

  initial begin
    nop = mk(0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    applyStimulus(nop, 1'b0, 1'b0);
    resetModel();
    #7;
    checkOutput("reset_pc_write",    pc_write,    1'b1);
    checkOutput("reset_ifid_write",  ifid_write,  1'b1);
    checkOutput("reset_ifid_flush",  ifid_flush,  1'b0);
    checkOutput("reset_idex_bubble", idex_bubble, 1'b0);
    checkOutput("reset_fwd_a",       fwd_a_sel,   2'b00);
    checkOutput("reset_fwd_b",       fwd_b_sel,   2'b00);
    checkOutput("reset_count",       stall_count, 0);
    checkOutput("reset_state",       state,       ST_RUN);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // add $3,$1,$2 ; add $4,$3,$1
    base = stall_count;
    issueInstr(mk(1, 1, 2, 1, 1, 3, 1, 0));
    issueInstr(mk(1, 3, 1, 1, 1, 4, 1, 0));
`ifdef HAZARD_FORWARDING_EN
    checkOutput("raw_ex_fwd_a", fwd_a_sel, 2'b10);
    checkOutput("raw_ex_stalls", stall_count - base, 0);
`else
    checkOutput("raw_ex_fwd_a", fwd_a_sel, 2'b00);
    checkOutput("raw_ex_stalls", stall_count - base, 2);
`endif
    issueInstr(nop);
    issueInstr(nop);

    // add $3,$1,$2 ; nop ; sub $5,$2,$3
    base = stall_count;
    issueInstr(mk(1, 1, 2, 1, 1, 3, 1, 0));
    issueInstr(nop);
    issueInstr(mk(1, 2, 3, 1, 1, 5, 1, 0));
`ifdef HAZARD_FORWARDING_EN
    checkOutput("raw_mem_fwd_b", fwd_b_sel, 2'b01);
    checkOutput("raw_mem_stalls", stall_count - base, 0);
`else
    checkOutput("raw_mem_fwd_b", fwd_b_sel, 2'b00);
    checkOutput("raw_mem_stalls", stall_count - base, 1);
`endif
    issueInstr(nop);
    issueInstr(nop);

    // lw $3,0($1) ; add $4,$3,$3
    base = stall_count;
    issueInstr(mk(1, 1, 0, 1, 0, 3, 1, 1));
    issueInstr(mk(1, 3, 3, 1, 1, 4, 1, 0));
`ifdef HAZARD_FORWARDING_EN
    checkOutput("load_use_fwd_a", fwd_a_sel, 2'b01);
    checkOutput("load_use_fwd_b", fwd_b_sel, 2'b01);
    checkOutput("load_use_stalls", stall_count - base, 1);
`else
    checkOutput("load_use_fwd_a", fwd_a_sel, 2'b00);
    checkOutput("load_use_fwd_b", fwd_b_sel, 2'b00);
    checkOutput("load_use_stalls", stall_count - base, 2);
`endif
    issueInstr(nop);
    issueInstr(nop);

    // add $0,$1,$2 ; add $5,$0,$0
    base = stall_count;
    issueInstr(mk(1, 1, 2, 1, 1, 0, 1, 0));
    issueInstr(mk(1, 0, 0, 1, 1, 5, 1, 0));
    checkOutput("zero_reg_fwd_a", fwd_a_sel, 2'b00);
    checkOutput("zero_reg_stalls", stall_count - base, 0);
    issueInstr(nop);
    issueInstr(nop);

    // Taken branch in the same cycle as a load-use hazard
    issueInstr(mk(1, 1, 0, 1, 0, 3, 1, 1));
    base = stall_count;
    applyStimulus(mk(1, 3, 3, 1, 1, 4, 1, 0), 1'b1, 1'b0);
    runCycle();
    checkOutput("branch_pc_write", exp_pc_write, 1'b1);
    checkOutput("branch_state", state, ST_FLUSH);
    checkOutput("branch_stalls", stall_count - base, 0);
    issueInstr(nop);
    issueInstr(nop);

    // Memory wait during a load-use stall
    issueInstr(mk(1, 1, 0, 1, 0, 3, 1, 1));
    applyStimulus(mk(1, 3, 1, 1, 1, 4, 1, 0), 1'b0, 1'b0);
    runCycle();
    checkOutput("frozen_entry_state", state, ST_LOAD_STALL);
    base = stall_count;
    applyStimulus(mk(1, 3, 1, 1, 1, 4, 1, 0), 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) runCycle();
    checkOutput("frozen_state", state, ST_LOAD_STALL);
    checkOutput("frozen_stalls", stall_count - base, 0);
    issueInstr(mk(1, 3, 1, 1, 1, 4, 1, 0));
`ifdef HAZARD_FORWARDING_EN
    checkOutput("frozen_resume_stalls", stall_count - base, 0);
`else
    checkOutput("frozen_resume_stalls", stall_count - base, 1);
`endif
    issueInstr(nop);
    issueInstr(nop);

    // Asynchronous reset in the middle of a stall
    issueInstr(mk(1, 1, 0, 1, 0, 3, 1, 1));
    applyStimulus(mk(1, 3, 1, 1, 1, 4, 1, 0), 1'b0, 1'b0);
    runCycle();
    applyStimulus(nop, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midreset_state",    state,       ST_RUN);
    checkOutput("midreset_count",    stall_count, 0);
    checkOutput("midreset_pc_write", pc_write,    1'b1);
    checkOutput("midreset_bubble",   idex_bubble, 1'b0);
    resetModel();
    #3;
    reset = 1'b0;

    // Random traffic over a small register set so dependencies are frequent
    for (int n = 0; n < 400; n++) begin
      applyStimulus(mk(bit'($urandom_range(0, 4) != 0),
                       5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                       bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                       5'($urandom_range(0, 3)), bit'($urandom_range(0, 3) != 0),
                       bit'($urandom_range(0, 2) == 0)),
                    bit'($urandom_range(0, 7) == 0), bit'($urandom_range(0, 7) == 0));
      runCycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", compare_count, miscompares);
    $finish;
  end

endmodule
